sd_block_rx: RTL and testbench

SPI-mode SD data-block receiver. It sits directly downstream of the SD command stage. Once the single-block read command has returned its R1 response, this block sees a `start` pulse. It then hunts for the data start token on D0 (card MISO), shifts in one data block, emits it as a byte stream with addresses, and receives and checks the trailing CRC16. It runs on the divided SD clock and does not drive CS or D1; those stay with the command stage.

---
 rtl/sd_block_rx_if.sv | 28 ++
 rtl/sd_block_rx.sv | 167 ++++++++++++++++
 tb/tb_sd_block_rx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sd_block_rx_if.sv
// Bus between the SD data-block receiver and its consumer.
// master: the receiver; slave: the command stage / byte sink side.
interface sd_block_rx_if;
    logic        start;
    logic        D0;
    logic        busy;
    logic [7:0]  byte_data;
    logic [8:0]  byte_addr;
    logic        byte_valid;
    logic        done;
    logic        err_timeout;
    logic        err_token;
    logic        err_crc;
    logic [3:0]  err_code;
    logic [15:0] crc_rx;

    modport master (
        input  start, D0,
        output busy, byte_data, byte_addr, byte_valid, done,
               err_timeout, err_token, err_crc, err_code, crc_rx
    );

    modport slave (
        output start, D0,
        input  busy, byte_data, byte_addr, byte_valid, done,
               err_timeout, err_token, err_crc, err_code, crc_rx
    );
endinterface

// File: rtl/sd_block_rx.sv
// SPI-mode SD single-block receiver: token hunt, byte stream out, CRC16 capture.
// Define SD_CRC16_CHECK_EN to build the CRC16-CCITT accumulator and drive err_crc.
module sd_block_rx #(
    parameter int BLOCK_BYTES   = 512,
    parameter int TOKEN_TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset_n,
    sd_block_rx_if.master bus
);
    localparam int                SLOT_W    = $clog2(TOKEN_TIMEOUT) + 1;
    localparam logic [9:0]        LAST_BYTE = 10'(BLOCK_BYTES - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(TOKEN_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, HUNT, DATA, CRC, FIN} state_t;

    state_t            state;
    logic [2:0]        bit_cnt;
    logic [6:0]        shift;
    logic [9:0]        byte_cnt;
    logic [SLOT_W-1:0] slot_cnt;
    logic              busy;
    logic [7:0]        byte_data;
    logic [8:0]        byte_addr;
    logic              byte_valid;
    logic              done;
    logic              err_timeout;
    logic              err_token;
    logic [3:0]        err_code;
    logic [15:0]       crc_rx;
    logic [7:0]        rx_byte;
    logic              byte_end;

    // The byte completing on this edge includes the bit currently on D0.
    assign rx_byte  = {shift, bus.D0};
    assign byte_end = (bit_cnt == 3'd7);

`ifdef SD_CRC16_CHECK_EN
    logic [15:0] crc_acc;
    logic        err_crc;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? 16'h1021 : 16'h0000);
    endfunction
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            shift       <= 7'd0;
            byte_cnt    <= 10'd0;
            slot_cnt    <= '0;
            busy        <= 1'b0;
            byte_data   <= 8'd0;
            byte_addr   <= 9'd0;
            byte_valid  <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            err_token   <= 1'b0;
            err_code    <= 4'd0;
            crc_rx      <= 16'd0;
`ifdef SD_CRC16_CHECK_EN
            crc_acc     <= 16'd0;
            err_crc     <= 1'b0;
`endif
        end else begin
            byte_valid <= 1'b0;
            done       <= 1'b0;
            if (state == HUNT || state == DATA) begin
                shift   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end
            case (state)
                IDLE: begin
                    bit_cnt  <= 3'd0;
                    byte_cnt <= 10'd0;
                    slot_cnt <= '0;
`ifdef SD_CRC16_CHECK_EN
                    crc_acc  <= 16'd0;
`endif
                    // Status from the previous block stays visible until a new start.
                    if (bus.start) begin
                        state       <= HUNT;
                        busy        <= 1'b1;
                        err_timeout <= 1'b0;
                        err_token   <= 1'b0;
                        err_code    <= 4'd0;
                        crc_rx      <= 16'd0;
`ifdef SD_CRC16_CHECK_EN
                        err_crc     <= 1'b0;
`endif
                    end
                end
                HUNT: begin
                    if (byte_end) begin
                        if (rx_byte == 8'hFF) begin
                            if (slot_cnt == LAST_SLOT) begin
                                err_timeout <= 1'b1;
                                state       <= FIN;
                            end else begin
                                slot_cnt <= slot_cnt + 1'b1;
                            end
                        end else if (rx_byte == 8'hFE) begin
                            state <= DATA;
                        end else begin
                            err_token <= 1'b1;
                            err_code  <= rx_byte[3:0];
                            state     <= FIN;
                        end
                    end
                end
                DATA: begin
`ifdef SD_CRC16_CHECK_EN
                    crc_acc <= crc16_step(crc_acc, bus.D0);
`endif
                    if (byte_end) begin
                        byte_data  <= rx_byte;
                        byte_addr  <= byte_cnt[8:0];
                        byte_valid <= 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= 10'd0;
                            state    <= CRC;
                        end else begin
                            byte_cnt <= byte_cnt + 10'd1;
                        end
                    end
                end
                CRC: begin
                    // byte_cnt is reused here as the 0..15 CRC bit index.
                    crc_rx <= {crc_rx[14:0], bus.D0};
                    if (byte_cnt[3:0] == 4'hF) begin
                        state <= FIN;
                    end else begin
                        byte_cnt <= byte_cnt + 10'd1;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef SD_CRC16_CHECK_EN
                    if (!err_timeout && !err_token) begin
                        err_crc <= (crc_acc != crc_rx);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.byte_data   = byte_data;
    assign bus.byte_addr   = byte_addr;
    assign bus.byte_valid  = byte_valid;
    assign bus.done        = done;
    assign bus.err_timeout = err_timeout;
    assign bus.err_token   = err_token;
    assign bus.err_code    = err_code;
    assign bus.crc_rx      = crc_rx;
`ifdef SD_CRC16_CHECK_EN
    assign bus.err_crc     = err_crc;
`else
    assign bus.err_crc     = 1'b0;
`endif
endmodule

// File: tb/tb_sd_block_rx.sv
// Directed bench for sd_block_rx: scoreboard of expected strobes plus status checks.
// Builds with or without SD_CRC16_CHECK_EN; the CRC-error expectation follows the macro.
module tb_sd_block_rx;
    localparam int BLOCK = 512;
    localparam int TMO   = 1024;
`ifdef SD_CRC16_CHECK_EN
    localparam logic EXP_CRC_ERR = 1'b1;
`else
    localparam logic EXP_CRC_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sd_block_rx_if bus();

    sd_block_rx #(.BLOCK_BYTES(BLOCK), .TOKEN_TIMEOUT(TMO)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct {
        logic [8:0] addr;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   strobes     = 0;
    int   cyc         = 0;
    int   start_cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference CRC16 (poly 0x1021, init 0), byte-at-a-time form.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    always @(negedge clk) begin
        if (bus.byte_valid) begin
            strobes++;
            if (sb.size() == 0) begin
                check("stray_strobe", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("byte_addr", bus.byte_addr, e.addr);
                check("byte_data", bus.byte_data, e.data);
                check("strobe_edge", cyc - start_cyc, e.at);
            end
        end
    end

    task automatic send_bit(input logic b);
        bus.D0 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic pulse_start);
        for (int i = 7; i >= 0; i--) begin
            bus.start = pulse_start && (i == 4);
            send_bit(b[i]);
        end
        bus.start = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, output int at, output logic bsy);
        at  = -1;
        bsy = 1'bx;
        for (int i = 0; i < budget; i++) begin
            send_bit(1'b1);
            if (bus.done) begin
                at  = cyc - start_cyc;
                bsy = bus.busy;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_byte_data"}, bus.byte_data, 0);
        check({tag, "_byte_addr"}, bus.byte_addr, 0);
        check({tag, "_byte_valid"}, bus.byte_valid, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_err_timeout"}, bus.err_timeout, 0);
        check({tag, "_err_token"}, bus.err_token, 0);
        check({tag, "_err_crc"}, bus.err_crc, 0);
        check({tag, "_err_code"}, bus.err_code, 0);
        check({tag, "_crc_rx"}, bus.crc_rx, 0);
    endtask

    task automatic run_block(input string tag, input int k, input logic [15:0] flip,
                             input int restart_byte);
        logic [15:0] crc;
        logic [15:0] sent;
        logic [7:0]  b;
        int          s0;
        int          at;
        logic        bsy;
        s0 = strobes;
        do_start();
        check({tag, "_busy_after_start"}, bus.busy, 1);
        for (int s = 0; s < k; s++) send_byte(8'hFF, 1'b0);
        send_byte(8'hFE, 1'b0);
        crc = 16'h0000;
        for (int i = 0; i < BLOCK; i++) begin
            b = i[7:0];
            sb.push_back('{addr: i[8:0], data: b, at: 8 * (k + 1) + 8 * (i + 1)});
            crc = crc_byte(crc, b);
            send_byte(b, i == restart_byte);
        end
        sent = crc ^ flip;
        send_byte(sent[15:8], 1'b0);
        send_byte(sent[7:0], 1'b0);
        wait_done(40, at, bsy);
        check({tag, "_done_edge"}, at, 8 * (k + 1) + 8 * BLOCK + 16 + 1);
        check({tag, "_busy_at_done"}, bsy, 0);
        check({tag, "_strobes"}, strobes - s0, BLOCK);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_err_timeout"}, bus.err_timeout, 0);
        check({tag, "_err_token"}, bus.err_token, 0);
        check({tag, "_crc_rx"}, bus.crc_rx, sent);
        check({tag, "_err_crc"}, bus.err_crc, (flip != 16'h0) ? EXP_CRC_ERR : 1'b0);
        repeat (3) send_bit(1'b1);
        check({tag, "_done_pulse_one_cycle"}, bus.done, 0);
        check({tag, "_crc_rx_hold"}, bus.crc_rx, sent);
        check({tag, "_err_crc_hold"}, bus.err_crc, (flip != 16'h0) ? EXP_CRC_ERR : 1'b0);
    endtask

    initial begin
        int   at;
        logic bsy;
        int   s0;
        bus.start = 1'b0;
        bus.D0    = 1'b1;
        reset_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) send_bit(1'b1);

        // Nominal block: token in slot 3, correct CRC.
        run_block("nominal", 3, 16'h0000, -1);

        // D0 stuck high: token timeout.
        s0 = strobes;
        do_start();
        wait_done(8 * TMO + 40, at, bsy);
        check("timeout_done_edge", at, 8 * TMO + 1);
        check("timeout_flag", bus.err_timeout, 1);
        check("timeout_busy_at_done", bsy, 0);
        check("timeout_strobes", strobes - s0, 0);
        check("timeout_err_token", bus.err_token, 0);

        // Error token 0x09 after one idle byte.
        s0 = strobes;
        do_start();
        send_byte(8'hFF, 1'b0);
        send_byte(8'h09, 1'b0);
        wait_done(40, at, bsy);
        check("token_done_edge", at, 17);
        check("token_flag", bus.err_token, 1);
        check("token_code", bus.err_code, 4'h9);
        check("token_timeout_clear", bus.err_timeout, 0);
        check("token_strobes", strobes - s0, 0);

        // Single flipped CRC bit.
        run_block("badcrc", 0, 16'h0001, -1);

        // Reset in the middle of data byte 100.
        s0 = strobes;
        do_start();
        send_byte(8'hFE, 1'b0);
        for (int i = 0; i < 100; i++) begin
            sb.push_back('{addr: i[8:0], data: i[7:0], at: 8 + 8 * (i + 1)});
            send_byte(i[7:0], 1'b0);
        end
        check("midreset_busy_before", bus.busy, 1);
        repeat (4) send_bit(1'b0);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (3) send_bit(1'b1);
        reset_n = 1'b1;
        repeat (100) send_bit(1'b1);
        check("midreset_strobes", strobes - s0, 100);
        check("midreset_sb_empty", sb.size(), 0);
        check("midreset_idle_busy", bus.busy, 0);

        // Clean block after the reset.
        run_block("after_reset", 1, 16'h0000, -1);

        // start re-pulsed inside data byte 50 must be ignored.
        run_block("restart_ignored", 2, 16'h0000, 50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
